// File: rtl/tof_bram_write_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// tof_pkg
// Shared constants and types for the ToF BRAM write arbiter slice.
//   N_CH      : number of sensor channels (power of two)
//   ZONE_W    : zone index width
//   DATA_W    : sample width
//   CH_W      : channel index width, derived from N_CH
//   OVR_CNT_W : width of the per-channel overrun counters
//   tof_word_t: one captured channel word {zone, sample}
// Optional feature macro used by the importing files: TOF_ARB_OVERRUN_CNT_EN
// ----------------------------------------------------------------------------
package tof_pkg;

    localparam int N_CH      = 8;
    localparam int ZONE_W    = 5;
    localparam int DATA_W    = 16;
    localparam int CH_W      = $clog2(N_CH);
    localparam int OVR_CNT_W = 8;

    typedef struct packed {
        logic [ZONE_W-1:0] zone;
        logic [DATA_W-1:0] sample;
    } tof_word_t;

    // Clear is applied first so a clear coinciding with a new loss leaves 1.
    function automatic logic [OVR_CNT_W-1:0] ovr_cnt_next(
        input logic [OVR_CNT_W-1:0] cnt,
        input logic                 clr,
        input logic                 evt
    );
        logic [OVR_CNT_W-1:0] base;
        base = clr ? '0 : cnt;
        if (evt && (base != {OVR_CNT_W{1'b1}})) begin
            base = base + 1'b1;
        end
        return base;
    endfunction

endpackage : tof_pkg

// File: rtl/tof_bram_write_arbiter_if.sv
// ----------------------------------------------------------------------------
// tof_bram_write_arbiter_if
// Bundles the sensor-side capture signals and the BRAM port A write signals.
//   ch_valid    : per-channel one-cycle data-ready pulses
//   ch_data     : per-channel {zone, sample} words, packed channel-major
//   overrun_clr : per-channel clear of the sticky overrun flags/counters
//   bram_we/bram_addr/bram_din : BRAM port A write, address {channel, zone}
//   pending     : holding register occupied, per channel
//   overrun     : sticky sample-lost flags, per channel
//   overrun_cnt : per-channel 8-bit saturating loss counters
//                 (only with TOF_ARB_OVERRUN_CNT_EN)
// Modports: master = sensor/BRAM environment side, slave = arbiter side.
// ----------------------------------------------------------------------------
interface tof_bram_write_arbiter_if
    import tof_pkg::*;
#(
    parameter int N_CH   = tof_pkg::N_CH,
    parameter int ZONE_W = tof_pkg::ZONE_W,
    parameter int DATA_W = tof_pkg::DATA_W
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int WORD_W = ZONE_W + DATA_W;

    logic [N_CH-1:0]        ch_valid;
    logic [N_CH*WORD_W-1:0] ch_data;
    logic [N_CH-1:0]        overrun_clr;
    logic                   bram_we;
    logic [CH_W+ZONE_W-1:0] bram_addr;
    logic [DATA_W-1:0]      bram_din;
    logic [N_CH-1:0]        pending;
    logic [N_CH-1:0]        overrun;
`ifdef TOF_ARB_OVERRUN_CNT_EN
    logic [N_CH*OVR_CNT_W-1:0] overrun_cnt;

    modport master (
        output ch_valid, ch_data, overrun_clr,
        input  bram_we, bram_addr, bram_din, pending, overrun, overrun_cnt
    );

    modport slave (
        input  ch_valid, ch_data, overrun_clr,
        output bram_we, bram_addr, bram_din, pending, overrun, overrun_cnt
    );
`else
    modport master (
        output ch_valid, ch_data, overrun_clr,
        input  bram_we, bram_addr, bram_din, pending, overrun
    );

    modport slave (
        input  ch_valid, ch_data, overrun_clr,
        output bram_we, bram_addr, bram_din, pending, overrun
    );
`endif

endinterface : tof_bram_write_arbiter_if

// File: rtl/tof_bram_write_arbiter_rr_arbiter.sv
// ----------------------------------------------------------------------------
// rr_arbiter
// Purely combinational round-robin arbiter. The search starts at ptr_i and
// wraps modulo N_CH; the first requesting channel wins. The owner of the
// pointer register advances it.
//   req_i       : request vector
//   ptr_i       : highest-priority channel this cycle
//   grant_o     : one-hot grant
//   grant_idx_o : encoded grant index (0 when nothing is granted)
//   any_grant_o : at least one request was granted
// ----------------------------------------------------------------------------
module rr_arbiter #(
    parameter int N_CH = 8,
    localparam int CH_W = $clog2(N_CH)
) (
    input  logic [N_CH-1:0] req_i,
    input  logic [CH_W-1:0] ptr_i,
    output logic [N_CH-1:0] grant_o,
    output logic [CH_W-1:0] grant_idx_o,
    output logic            any_grant_o
);

    // Walk the channels starting at the pointer; the CH_W-bit sum wraps
    // naturally because N_CH is a power of two.
    always_comb begin
        logic [CH_W-1:0] cand;
        logic            found;
        cand        = '0;
        found       = 1'b0;
        grant_idx_o = '0;
        grant_o     = '0;
        for (int k = 0; k < N_CH; k++) begin
            cand = ptr_i + CH_W'(k);
            if (!found && req_i[cand]) begin
                found       = 1'b1;
                grant_idx_o = cand;
            end
        end
        if (found) begin
            grant_o[grant_idx_o] = 1'b1;
        end
        any_grant_o = found;
    end

endmodule : rr_arbiter

// File: rtl/tof_bram_write_arbiter.sv
// ----------------------------------------------------------------------------
// tof_bram_write_arbiter
// Round-robin write arbiter between the ToF sensor I2C channels and port A
// of the ToF data BRAM. Each data-ready pulse captures its channel word in a
// holding register; pending words are drained one BRAM write per cycle at
// address {channel, zone}. A new word arriving while the previous one is
// still held (and not being written this cycle) replaces it and raises the
// channel's sticky overrun flag.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset, clears all state
//   bus   : tof_bram_write_arbiter_if.slave (capture inputs, BRAM write,
//           pending/overrun status, overrun clear)
// Optional feature: define TOF_ARB_OVERRUN_CNT_EN to add per-channel 8-bit
// saturating overrun counters on bus.overrun_cnt.
// ----------------------------------------------------------------------------
module tof_bram_write_arbiter
    import tof_pkg::*;
#(
    parameter int N_CH   = tof_pkg::N_CH,
    parameter int ZONE_W = tof_pkg::ZONE_W,
    parameter int DATA_W = tof_pkg::DATA_W
) (
    input logic                     clk,
    input logic                     rst_n,
    tof_bram_write_arbiter_if.slave bus
);

    localparam int CH_W   = $clog2(N_CH);
    localparam int WORD_W = ZONE_W + DATA_W;

    typedef struct packed {
        logic [ZONE_W-1:0] zone;
        logic [DATA_W-1:0] sample;
    } word_t;

    word_t                  hold_q [N_CH];
    word_t                  hold_d [N_CH];
    logic [N_CH-1:0]        pending_q, pending_d;
    logic [N_CH-1:0]        overrun_q, overrun_d;
    logic [CH_W-1:0]        rr_ptr_q, rr_ptr_d;
    logic                   bram_we_q, bram_we_d;
    logic [CH_W+ZONE_W-1:0] bram_addr_q, bram_addr_d;
    logic [DATA_W-1:0]      bram_din_q, bram_din_d;

    logic [N_CH-1:0]        grant;
    logic [CH_W-1:0]        grant_idx;
    logic                   any_grant;
    logic [N_CH-1:0]        ovr_evt;

    rr_arbiter #(
        .N_CH (N_CH)
    ) u_rr_arbiter (
        .req_i       (pending_q),
        .ptr_i       (rr_ptr_q),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .any_grant_o (any_grant)
    );

    // A pulse on the channel being granted is not a loss: the held word is
    // written this cycle and the new word takes its place.
    always_comb begin
        ovr_evt     = bus.ch_valid & pending_q & ~grant;
        pending_d   = bus.ch_valid | (pending_q & ~grant);
        overrun_d   = ovr_evt | (overrun_q & ~bus.overrun_clr);
        bram_we_d   = any_grant;
        bram_addr_d = bram_addr_q;
        bram_din_d  = bram_din_q;
        rr_ptr_d    = rr_ptr_q;
        for (int i = 0; i < N_CH; i++) begin
            hold_d[i] = bus.ch_valid[i] ? word_t'(bus.ch_data[i*WORD_W +: WORD_W])
                                        : hold_q[i];
        end
        if (any_grant) begin
            bram_addr_d = {grant_idx, hold_q[grant_idx].zone};
            bram_din_d  = hold_q[grant_idx].sample;
            rr_ptr_d    = grant_idx + CH_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            overrun_q   <= '0;
            rr_ptr_q    <= '0;
            bram_we_q   <= 1'b0;
            bram_addr_q <= '0;
            bram_din_q  <= '0;
            for (int i = 0; i < N_CH; i++) begin
                hold_q[i] <= '0;
            end
        end else begin
            pending_q   <= pending_d;
            overrun_q   <= overrun_d;
            rr_ptr_q    <= rr_ptr_d;
            bram_we_q   <= bram_we_d;
            bram_addr_q <= bram_addr_d;
            bram_din_q  <= bram_din_d;
            for (int i = 0; i < N_CH; i++) begin
                hold_q[i] <= hold_d[i];
            end
        end
    end

    assign bus.bram_we   = bram_we_q;
    assign bus.bram_addr = bram_addr_q;
    assign bus.bram_din  = bram_din_q;
    assign bus.pending   = pending_q;
    assign bus.overrun   = overrun_q;

`ifdef TOF_ARB_OVERRUN_CNT_EN
    logic [OVR_CNT_W-1:0] ovr_cnt_q [N_CH];
    logic [OVR_CNT_W-1:0] ovr_cnt_d [N_CH];

    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            ovr_cnt_d[i] = ovr_cnt_next(ovr_cnt_q[i], bus.overrun_clr[i], ovr_evt[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                ovr_cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                ovr_cnt_q[i] <= ovr_cnt_d[i];
            end
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_cnt_out
        assign bus.overrun_cnt[g*OVR_CNT_W +: OVR_CNT_W] = ovr_cnt_q[g];
    end
`endif

endmodule : tof_bram_write_arbiter

// File: tb/tb_tof_bram_write_arbiter.sv
// ----------------------------------------------------------------------------
// tb_tof_bram_write_arbiter
// Self-checking bench for tof_bram_write_arbiter: directed scenarios followed
// by random traffic, all compared against a behavioural channel model.
// Honours TOF_ARB_OVERRUN_CNT_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_tof_bram_write_arbiter;
    import tof_pkg::*;

    localparam int WORD_W = ZONE_W + DATA_W;
    localparam int DW     = N_CH * WORD_W;

    logic clk;
    logic rst_n;

    tof_bram_write_arbiter_if bus ();

    tof_bram_write_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int passCount  = 0;
    int checkCount = 0;

    // Behavioural model: each channel is a one-deep mailbox; the writer
    // visits channels in circular order starting after the last one served.
    bit        mPend [N_CH];
    tof_word_t mWord [N_CH];
    bit        mOvr  [N_CH];
    int        mCnt  [N_CH];
    int        mPtr;
    bit        mWe;
    int        mAddr;
    int        mDin;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed !== expected)
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        else
            passCount++;
    endtask

    task automatic modelReset();
        for (int i = 0; i < N_CH; i++) begin
            mPend[i] = 1'b0;
            mWord[i] = '0;
            mOvr[i]  = 1'b0;
            mCnt[i]  = 0;
        end
        mPtr  = 0;
        mWe   = 1'b0;
        mAddr = 0;
        mDin  = 0;
    endtask

    task automatic modelStep(input logic [N_CH-1:0] v, input logic [DW-1:0] d,
                             input logic [N_CH-1:0] clr);
        int  g;
        bit  found;
        bit  granted;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < N_CH; k++) begin
            if (!found && mPend[(mPtr + k) % N_CH]) begin
                found = 1'b1;
                g     = (mPtr + k) % N_CH;
            end
        end
        mWe = found;
        if (found) begin
            mAddr = g * (1 << ZONE_W) + int'(mWord[g].zone);
            mDin  = int'(mWord[g].sample);
            mPtr  = (g + 1) % N_CH;
        end
        for (int i = 0; i < N_CH; i++) begin
            granted = found && (g == i);
            if (clr[i]) begin
                mOvr[i] = 1'b0;
                mCnt[i] = 0;
            end
            if (v[i] && mPend[i] && !granted) begin
                mOvr[i] = 1'b1;
                if (mCnt[i] < 255) mCnt[i]++;
            end
            if (granted) mPend[i] = 1'b0;
            if (v[i]) begin
                mPend[i] = 1'b1;
                mWord[i] = tof_word_t'(d[i*WORD_W +: WORD_W]);
            end
        end
    endtask

    function automatic logic [N_CH-1:0] packBits(input bit b [N_CH]);
        logic [N_CH-1:0] r;
        for (int i = 0; i < N_CH; i++) r[i] = b[i];
        return r;
    endfunction

    task automatic checkAll();
        checkOutput("bram_we",   64'(bus.bram_we),   64'(mWe));
        checkOutput("bram_addr", 64'(bus.bram_addr), 64'(mAddr));
        checkOutput("bram_din",  64'(bus.bram_din),  64'(mDin));
        checkOutput("pending",   64'(bus.pending),   64'(packBits(mPend)));
        checkOutput("overrun",   64'(bus.overrun),   64'(packBits(mOvr)));
`ifdef TOF_ARB_OVERRUN_CNT_EN
        for (int i = 0; i < N_CH; i++)
            checkOutput("overrun_cnt", 64'(bus.overrun_cnt[i*OVR_CNT_W +: OVR_CNT_W]),
                        64'(mCnt[i]));
`endif
    endtask

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] d;
        for (int i = 0; i < N_CH; i++) d[i*WORD_W +: WORD_W] = WORD_W'($urandom);
        return d;
    endfunction

    function automatic logic [DW-1:0] withWord(input logic [DW-1:0] d, input int ch,
                                               input int zone, input int sample);
        d[ch*WORD_W +: WORD_W] = {ZONE_W'(zone), DATA_W'(sample)};
        return d;
    endfunction

    // Drive one cycle of inputs (called just after a falling edge), let the
    // model take the same rising edge, then check at the next falling edge.
    task automatic applyStimulus(input logic [N_CH-1:0] v, input logic [DW-1:0] d,
                                 input logic [N_CH-1:0] clr);
        bus.ch_valid    = v;
        bus.ch_data     = d;
        bus.overrun_clr = clr;
        @(posedge clk);
        modelStep(v, d, clr);
        @(negedge clk);
        bus.ch_valid    = '0;
        bus.overrun_clr = '0;
        checkAll();
    endtask

    task automatic idle();
        applyStimulus('0, randData(), '0);
    endtask

    // Reset with garbage on the inputs; everything must read zero.
    task automatic doReset();
        bus.ch_valid    = N_CH'($urandom);
        bus.ch_data     = randData();
        bus.overrun_clr = N_CH'($urandom);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        modelReset();
        checkAll();
        bus.ch_valid    = '0;
        bus.overrun_clr = '0;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [DW-1:0] d;
        rst_n = 1'b0;
        bus.ch_valid    = '0;
        bus.ch_data     = '0;
        bus.overrun_clr = '0;
        modelReset();
        @(negedge clk);

        // Reset, then a single write from channel 3.
        doReset();
        applyStimulus(8'h08, withWord(randData(), 3, 7, 16'hBEEF), '0);
        checkOutput("t1_capture_no_we", 64'(bus.bram_we), 64'd0);
        idle();
        checkOutput("t1_we",   64'(bus.bram_we),   64'd1);
        checkOutput("t1_addr", 64'(bus.bram_addr), 64'h67);
        checkOutput("t1_din",  64'(bus.bram_din),  64'hBEEF);
        idle();
        checkOutput("t1_we_drop", 64'(bus.bram_we), 64'd0);

        // All-channel burst from a fresh pointer.
        doReset();
        d = '0;
        for (int i = 0; i < N_CH; i++) d = withWord(d, i, i, 16'h1000 + i);
        applyStimulus('1, d, '0);
        for (int i = 0; i < N_CH; i++) begin
            idle();
            checkOutput("burst_we",   64'(bus.bram_we),   64'd1);
            checkOutput("burst_addr", 64'(bus.bram_addr), 64'((i << ZONE_W) | i));
            checkOutput("burst_din",  64'(bus.bram_din),  64'(16'h1000 + i));
        end
        checkOutput("burst_empty", 64'(bus.pending), 64'd0);
        idle();
        checkOutput("burst_we_end", 64'(bus.bram_we), 64'd0);

        // Round-robin wrap: after ch4, ch6 beats ch2.
        applyStimulus(8'h10, randData(), '0);
        idle();
        applyStimulus(8'h44, randData(), '0);
        idle();
        checkOutput("wrap_first", 64'(bus.bram_addr[ZONE_W +: CH_W]), 64'd6);
        idle();
        checkOutput("wrap_second", 64'(bus.bram_addr[ZONE_W +: CH_W]), 64'd2);

        // Same-channel grant and new pulse.
        applyStimulus(8'h02, withWord(randData(), 1, 0, 16'h0001), '0);
        applyStimulus(8'h02, withWord(randData(), 1, 0, 16'h0002), '0);
        checkOutput("same_first", 64'(bus.bram_din), 64'h0001);
        idle();
        checkOutput("same_second", 64'(bus.bram_din), 64'h0002);
        checkOutput("same_no_ovr", 64'(bus.overrun[1]), 64'd0);

        // Overrun on ch5 while ch0 is granted.
        applyStimulus(8'h80, randData(), '0);
        idle();
        d = withWord(randData(), 0, 1, 16'h1111);
        applyStimulus(8'h21, withWord(d, 5, 2, 16'h5555), '0);
        applyStimulus(8'h20, withWord(randData(), 5, 3, 16'hAAAA), '0);
        checkOutput("ovr_flag", 64'(bus.overrun[5]), 64'd1);
        idle();
        checkOutput("ovr_newest", 64'(bus.bram_din), 64'hAAAA);

        // Continuous pulses on ch4 and ch5: each loses every other cycle.
        for (int n = 0; n < 700; n++) applyStimulus(8'h30, randData(), '0);
        checkOutput("ovr_sticky", 64'(bus.overrun[5]), 64'd1);
`ifdef TOF_ARB_OVERRUN_CNT_EN
        checkOutput("cnt_sat", 64'(bus.overrun_cnt[5*OVR_CNT_W +: OVR_CNT_W]), 64'd255);
`endif
        applyStimulus('0, randData(), 8'h20);
        checkOutput("clr_flag", 64'(bus.overrun[5]), 64'd0);
`ifdef TOF_ARB_OVERRUN_CNT_EN
        checkOutput("clr_cnt", 64'(bus.overrun_cnt[5*OVR_CNT_W +: OVR_CNT_W]), 64'd0);
`endif
        repeat (3) idle();

        // Mid-burst asynchronous reset.
        applyStimulus(8'h66, randData(), '0);
        idle();
        checkOutput("pre_rst_we", 64'(bus.bram_we), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst_we_async",   64'(bus.bram_we), 64'd0);
        checkOutput("rst_pend_async", 64'(bus.pending), 64'd0);
        modelReset();
        checkAll();
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            idle();
            checkOutput("no_wr_after_rst", 64'(bus.bram_we), 64'd0);
        end

        // Random traffic including clears.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(N_CH'($urandom & $urandom), randData(),
                          ($urandom_range(0, 15) == 0) ? N_CH'($urandom) : '0);
        end
        repeat (N_CH + 1) idle();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_tof_bram_write_arbiter
